tl_ul_port_arbiter: RTL

Round-robin arbiter that shares one TileLink-UL port (26-bit address, 32-bit data, 4-bit mask) between `NUM_MASTERS` requesters. It sits upstream of the TL monitor and slave on the peripheral bus. On the A channel it grants one master at a time and holds the grant across multi-beat bursts. It tags `a_source` with the master index and routes D-channel responses back by that tag.

---
 rtl/tl_ul_port_arbiter_if.sv | 38 +++
 rtl/tl_ul_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_port_arbiter_if.sv
// TileLink-UL link bundle, LANES requesters wide on the A side and on D valid/ready.
// Latency: none; wires only. D payload fields are a single broadcast copy.
// Backpressure: a_ready/d_ready travel opposite to a_valid/d_valid on every lane.
// Ports: master modport drives A and d_ready; slave modport drives a_ready and D.
interface tl_ul_port_arbiter_if #(
    parameter int LANES = 1,
    parameter int SRC_W = 1
);
    logic [LANES-1:0]       a_valid;
    logic [LANES-1:0]       a_ready;
    logic [3*LANES-1:0]     a_opcode;
    logic [3*LANES-1:0]     a_param;
    logic [3*LANES-1:0]     a_size;
    logic [SRC_W*LANES-1:0] a_source;
    logic [26*LANES-1:0]    a_address;
    logic [4*LANES-1:0]     a_mask;
    logic [32*LANES-1:0]    a_data;

    logic [LANES-1:0]       d_valid;
    logic [LANES-1:0]       d_ready;
    logic [2:0]             d_opcode;
    logic [1:0]             d_param;
    logic [2:0]             d_size;
    logic [SRC_W-1:0]       d_source;
    logic                   d_denied;
    logic                   d_corrupt;
    logic [31:0]            d_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
    );
endinterface

// File: rtl/tl_ul_port_arbiter.sv
// Round-robin arbiter sharing one TL-UL port among NUM_MASTERS requesters, grant held across A bursts.
// Latency: zero; A and D are combinational pass-through with no buffering.
// Backpressure: s_a_ready reaches only the granted master; s_d_ready mirrors the routed master's d_ready.
// Ports: clock, reset (async, active-high); m = upstream requesters (packed, master i at slice i);
//        s = downstream port, source widened by the master index in its top IW bits.
// Optional: define TL_ARB_INFLIGHT_LIMIT_EN to cap outstanding requests per master at MAX_INFLIGHT.
module tl_ul_port_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int SRC_W        = 1,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    tl_ul_port_arbiter_if.slave  m,
    tl_ul_port_arbiter_if.master s
);
    localparam int N    = NUM_MASTERS;
    localparam int IW   = $clog2(NUM_MASTERS);
    localparam bit POW2 = ((1 << IW) == N);

    typedef enum logic {IDLE, BURST} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic [3:0]      a_beats_q, a_beats_d;

    logic [N-1:0]    capped, eligible;
    logic [IW-1:0]   grant_idx, sel_idx, d_idx;
    logic            any_elig, a_vld, a_fire, a_multi, d_in_range, d_rdy;
    logic [2:0]      sel_opcode, sel_size;
    logic [4:0]      a_beats_total;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    assign eligible = m.a_valid & ~capped;

    // First eligible master at or after rr_ptr; descending k lets the nearest one win.
    always_comb begin
        grant_idx = rr_ptr_q;
        any_elig  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr_q) + k) % N]) begin
                grant_idx = IW'((int'(rr_ptr_q) + k) % N);
                any_elig  = 1'b1;
            end
        end
    end

    assign sel_idx    = (state_q == BURST) ? lock_idx_q : grant_idx;
    assign sel_opcode = m.a_opcode[3*sel_idx +: 3];
    assign sel_size   = m.a_size[3*sel_idx +: 3];

    // Only Put opcodes (0/1) larger than one word span several beats.
    assign a_multi       = (sel_opcode[2:1] == 2'b00) && (sel_size > 3'd2);
    assign a_beats_total = 5'd1 << (sel_size - 3'd2);

    always_comb begin
        a_vld     = 1'b0;
        m.a_ready = '0;
        if (!reset) begin
            // In BURST the locked master keeps the port even if it is now capped.
            a_vld = (state_q == BURST) ? m.a_valid[lock_idx_q] : any_elig;
            if (state_q == BURST || any_elig) begin
                m.a_ready[sel_idx] = s.a_ready[0];
            end
        end
    end

    assign a_fire      = a_vld & s.a_ready[0];
    assign s.a_valid   = a_vld;
    assign s.a_opcode  = sel_opcode;
    assign s.a_size    = sel_size;
    assign s.a_param   = m.a_param[3*sel_idx +: 3];
    assign s.a_source  = {sel_idx, m.a_source[SRC_W*sel_idx +: SRC_W]};
    assign s.a_address = m.a_address[26*sel_idx +: 26];
    assign s.a_mask    = m.a_mask[4*sel_idx +: 4];
    assign s.a_data    = m.a_data[32*sel_idx +: 32];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        a_beats_d  = a_beats_q;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    if (a_multi) begin
                        state_d    = BURST;
                        lock_idx_d = grant_idx;
                        // Counts beats still owed after the next one; zero marks the last beat.
                        a_beats_d  = 4'(a_beats_total - 5'd2);
                    end else begin
                        rr_ptr_d = idx_inc(grant_idx);
                    end
                end
            end
            BURST: begin
                if (a_fire) begin
                    if (a_beats_q == 4'd0) begin
                        state_d  = IDLE;
                        rr_ptr_d = idx_inc(lock_idx_q);
                    end else begin
                        a_beats_d = a_beats_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            a_beats_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            a_beats_q  <= a_beats_d;
        end
    end

    // D routing by the index tag in the top source bits; unknown indices are sunk.
    assign d_idx      = s.d_source[IW+SRC_W-1 -: IW];
    assign d_in_range = POW2 || (int'(d_idx) < N);

    always_comb begin
        m.d_valid = '0;
        d_rdy     = 1'b0;
        if (!reset) begin
            if (d_in_range) begin
                m.d_valid[d_idx] = s.d_valid[0];
                d_rdy            = m.d_ready[d_idx];
            end else begin
                d_rdy = 1'b1;
            end
        end
    end

    assign s.d_ready   = d_rdy;
    assign m.d_opcode  = s.d_opcode;
    assign m.d_param   = s.d_param;
    assign m.d_size    = s.d_size;
    assign m.d_source  = s.d_source[SRC_W-1:0];
    assign m.d_denied  = s.d_denied;
    assign m.d_corrupt = s.d_corrupt;
    assign m.d_data    = s.d_data;

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] cnt_q[N], cnt_d[N];
    logic [3:0]    d_beats_q[N], d_beats_d[N];
    logic [3:0]    d_total_m1;
    logic          d_fire, d_last;
    logic [N-1:0]  cnt_inc, cnt_dec;

    always_comb begin
        d_fire     = s.d_valid[0] & d_rdy & d_in_range;
        d_total_m1 = 4'd0;
        if (s.d_opcode == 3'd1 && s.d_size > 3'd2) begin
            d_total_m1 = 4'((5'd1 << (s.d_size - 3'd2)) - 5'd1);
        end
        d_last = (d_beats_q[d_idx] == d_total_m1);
        for (int i = 0; i < N; i++) begin
            cnt_inc[i]   = (state_q == IDLE) && a_fire && (grant_idx == IW'(i));
            cnt_dec[i]   = d_fire && d_last && (d_idx == IW'(i));
            cnt_d[i]     = cnt_q[i];
            d_beats_d[i] = d_beats_q[i];
            if (cnt_inc[i] && !cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            if (d_fire && d_idx == IW'(i)) begin
                d_beats_d[i] = d_last ? 4'd0 : d_beats_q[i] + 4'd1;
            end
            capped[i] = (cnt_q[i] == CW'(MAX_INFLIGHT));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i]     <= '0;
                d_beats_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i]     <= cnt_d[i];
                d_beats_q[i] <= d_beats_d[i];
            end
        end
    end
`else
    assign capped = '0;
`endif
endmodule
